// File: rtl/seed_f_sequencer.sv
// SEED round F-function sequencer: drives three dependent evaluations through a
// shared, arbitrated G unit and performs the mod-2^32 additions between them.
module seed_f_sequencer #(
  parameter int G_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  input  logic [31:0] in_k0,
  input  logic [31:0] in_k1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_c,
  output logic [31:0] out_d,
  output logic        g_req,
  input  logic        g_gnt,
  output logic [31:0] g_x,
  input  logic [31:0] g_y
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] G1   = 3'd1;
  localparam logic [2:0] G2   = 3'd2;
  localparam logic [2:0] G3   = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]  state;
  logic [31:0] a, b, t, u;
  logic [31:0] outC, outD;
  logic        waitFlag;
  logic        inG, fire, capture;

  function automatic logic [31:0] addMod(input logic [31:0] x, input logic [31:0] y);
    return x + y;
  endfunction

  always_comb begin
    inG   = (state == G1) || (state == G2) || (state == G3);
    g_req = inG && !waitFlag;
    fire  = g_req && g_gnt;
    // With a registered G unit the result is taken at the end of the wait cycle.
    capture = (G_LAT == 0) ? fire : (inG && waitFlag);
    case (state)
      G1:      g_x = a ^ b;
      G2:      g_x = addMod(t, a);
      G3:      g_x = addMod(u, t);
      default: g_x = '0;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_c     = outC;
  assign out_d     = outD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      t        <= '0;
      u        <= '0;
      outC     <= '0;
      outD     <= '0;
      waitFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a     <= in_c ^ in_k0;
            b     <= in_d ^ in_k1;
            state <= G1;
          end
        end
        G1, G2, G3: begin
          if (capture) begin
            waitFlag <= 1'b0;
            case (state)
              G1: begin
                t     <= g_y;
                state <= G2;
              end
              G2: begin
                u     <= g_y;
                state <= G3;
              end
              default: begin
                outD  <= g_y;
                outC  <= addMod(g_y, u);
                state <= DONE;
              end
            endcase
          end else if (fire) begin
            waitFlag <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seed_f_sequencer.sv
// Bench for seed_f_sequencer: one instance per G latency, each with its own G stub,
// checked transaction by transaction against a word-level model of the F function.
module tb_seed_f_sequencer;

  logic        clk;
  logic        rst_n;
  logic        inValid  [2];
  logic        inReady  [2];
  logic [31:0] inC      [2];
  logic [31:0] inD      [2];
  logic [31:0] inK0     [2];
  logic [31:0] inK1     [2];
  logic        outValid [2];
  logic        outReady [2];
  logic [31:0] outC     [2];
  logic [31:0] outD     [2];
  logic        gReq     [2];
  logic        gGnt     [2];
  logic [31:0] gX       [2];
  logic [31:0] gY       [2];

  logic        stubMode;
  logic [31:0] gyReg;
  int          nChecks, nErrors;
  logic [31:0] gxLog [2][256];
  int          nLog  [2];
  int          reqCyc[2];

  seed_f_sequencer #(.G_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_c(inC[0]), .in_d(inD[0]), .in_k0(inK0[0]), .in_k1(inK1[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_c(outC[0]), .out_d(outD[0]),
    .g_req(gReq[0]), .g_gnt(gGnt[0]), .g_x(gX[0]), .g_y(gY[0])
  );

  seed_f_sequencer #(.G_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_c(inC[1]), .in_d(inD[1]), .in_k0(inK0[1]), .in_k1(inK1[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_c(outC[1]), .out_d(outD[1]),
    .g_req(gReq[1]), .g_gnt(gGnt[1]), .g_x(gX[1]), .g_y(gY[1])
  );

  function automatic logic [31:0] scramble(input logic [31:0] x);
    return {x[20:0], x[31:21]} ^ 32'h9E3779B9;
  endfunction

  function automatic logic [31:0] gFun(input logic [31:0] x);
    return stubMode ? scramble(x) : x;
  endfunction

  // G stubs: combinational for instance 0, one-cycle registered for instance 1.
  assign gY[0] = stubMode ? scramble(gX[0]) : gX[0];
  assign gY[1] = gyReg;
  always @(posedge clk) if (gReq[1] && gGnt[1]) gyReg <= stubMode ? scramble(gX[1]) : gX[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    nLog[0] = 0; nLog[1] = 0; reqCyc[0] = 0; reqCyc[1] = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (gReq[i] && gGnt[i]) begin
          gxLog[i][nLog[i] % 256] = gX[i];
          nLog[i] = nLog[i] + 1;
        end
        if (gReq[i]) reqCyc[i] = reqCyc[i] + 1;
      end
    end
  end

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level F function reference with the current G stub.
  task automatic model(input logic [31:0] c, d, k0, k1,
                       output logic [31:0] eC, eD, x0, x1, x2);
    logic [31:0] a, b, t, u, r;
    a  = c ^ k0;
    b  = d ^ k1;
    x0 = a ^ b;
    t  = gFun(x0);
    x1 = t + a;
    u  = gFun(x1);
    x2 = u + t;
    r  = gFun(x2);
    eD = r;
    eC = r + u;
  endtask

  task automatic transact(input int idx, input logic [31:0] c, d, k0, k1,
                          input int stall, input int hold, input string tag);
    logic [31:0] eC, eD, x0, x1, x2, stallGx;
    int edges, stalled, busyBad, doneBad, stallBad, baseLog, baseReq;
    bit seen;
    model(c, d, k0, k1, eC, eD, x0, x1, x2);
    stalled = 0; busyBad = 0; doneBad = 0; stallBad = 0; seen = 0; stallGx = '0;
    baseLog = nLog[idx];
    baseReq = reqCyc[idx];
    @(negedge clk);
    inC[idx] = c; inD[idx] = d; inK0[idx] = k0; inK1[idx] = k1;
    inValid[idx] = 1'b1; outReady[idx] = 1'b0; gGnt[idx] = 1'b1;
    checkEq($sformatf("%s[%0d] in_ready idle", tag, idx), inReady[idx], 1);
    @(posedge clk);
    edges = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (outValid[idx]) begin
        seen = 1;
        break;
      end
      if (inReady[idx]) busyBad++;
      inC[idx] = $urandom; inD[idx] = $urandom; inK0[idx] = $urandom; inK1[idx] = $urandom;
      if (gReq[idx] && (nLog[idx] - baseLog == 1) && stalled < stall) begin
        gGnt[idx] = 1'b0;
        if (stalled > 0 && gX[idx] !== stallGx) stallBad++;
        stallGx = gX[idx];
        stalled++;
      end else begin
        gGnt[idx] = 1'b1;
      end
      @(posedge clk);
      edges++;
    end
    checkEq($sformatf("%s[%0d] done reached", tag, idx), seen, 1);
    checkEq($sformatf("%s[%0d] latency", tag, idx), edges, (idx == 0 ? 4 : 7) + stall);
    outReady[idx] = (hold == 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!outValid[idx] || outC[idx] !== eC || outD[idx] !== eD || gReq[idx] || inReady[idx])
        doneBad++;
      if (h == hold - 1) outReady[idx] = 1'b1;
    end
    checkEq($sformatf("%s[%0d] out_d", tag, idx), outD[idx], eD);
    checkEq($sformatf("%s[%0d] out_c", tag, idx), outC[idx], eC);
    checkEq($sformatf("%s[%0d] g_x in done", tag, idx), gX[idx], 0);
    checkEq($sformatf("%s[%0d] in_ready in done", tag, idx), inReady[idx], 0);
    checkEq($sformatf("%s[%0d] done hold stable", tag, idx), doneBad, 0);
    @(posedge clk);
    #1;
    inValid[idx] = 1'b0;
    outReady[idx] = 1'b0;
    checkEq($sformatf("%s[%0d] out_valid after handoff", tag, idx), outValid[idx], 0);
    checkEq($sformatf("%s[%0d] in_ready after handoff", tag, idx), inReady[idx], 1);
    checkEq($sformatf("%s[%0d] out_c kept", tag, idx), outC[idx], eC);
    checkEq($sformatf("%s[%0d] fire count", tag, idx), nLog[idx] - baseLog, 3);
    checkEq($sformatf("%s[%0d] g_x #1", tag, idx), gxLog[idx][baseLog % 256], x0);
    checkEq($sformatf("%s[%0d] g_x #2", tag, idx), gxLog[idx][(baseLog + 1) % 256], x1);
    checkEq($sformatf("%s[%0d] g_x #3", tag, idx), gxLog[idx][(baseLog + 2) % 256], x2);
    checkEq($sformatf("%s[%0d] g_req cycles", tag, idx), reqCyc[idx] - baseReq, 3 + stall);
    checkEq($sformatf("%s[%0d] in_ready while busy", tag, idx), busyBad, 0);
    if (stall > 0) begin
      checkEq($sformatf("%s[%0d] stall g_x held", tag, idx), stallBad, 0);
      checkEq($sformatf("%s[%0d] stall g_x value", tag, idx), stallGx, x1);
    end
  endtask

  task automatic abortInG2(input int idx);
    int baseLog;
    bit reached;
    baseLog = nLog[idx];
    reached = 0;
    @(negedge clk);
    inC[idx] = 32'h1; inD[idx] = 32'h2; inK0[idx] = '0; inK1[idx] = '0;
    inValid[idx] = 1'b1; gGnt[idx] = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      inValid[idx] = 1'b0;
      if (gReq[idx] && (nLog[idx] - baseLog == 1)) begin
        reached = 1;
        break;
      end
    end
    checkEq($sformatf("abort[%0d] reached G2", idx), reached, 1);
    #2 rst_n = 1'b0;
    #1;
    checkEq($sformatf("abort[%0d] out_valid", idx), outValid[idx], 0);
    checkEq($sformatf("abort[%0d] g_req", idx), gReq[idx], 0);
    checkEq($sformatf("abort[%0d] g_x", idx), gX[idx], 0);
    checkEq($sformatf("abort[%0d] out_c", idx), outC[idx], 0);
    checkEq($sformatf("abort[%0d] out_d", idx), outD[idx], 0);
    checkEq($sformatf("abort[%0d] in_ready", idx), inReady[idx], 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    nChecks = 0; nErrors = 0;
    stubMode = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inValid[i] = 1'b0; outReady[i] = 1'b0; gGnt[i] = 1'b1;
      inC[i] = '0; inD[i] = '0; inK0[i] = '0; inK1[i] = '0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      checkEq($sformatf("reset[%0d] in_ready", i), inReady[i], 1);
      checkEq($sformatf("reset[%0d] out_valid", i), outValid[i], 0);
      checkEq($sformatf("reset[%0d] g_req", i), gReq[i], 0);
      checkEq($sformatf("reset[%0d] g_x", i), gX[i], 0);
      checkEq($sformatf("reset[%0d] out_c", i), outC[i], 0);
      checkEq($sformatf("reset[%0d] out_d", i), outD[i], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++) begin
      transact(i, 32'h1, 32'h2, 32'h0, 32'h0, 0, 0, "basic");
      transact(i, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 0, 0, "wrap");
      transact(i, 32'h1, 32'h2, 32'h0, 32'h0, 5, 0, "stall");
      transact(i, 32'h1, 32'h2, 32'h0, 32'h0, 0, 3, "hold");
      transact(i, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 32'hF0F0F0F0, 0, 0, "backtoback");
    end

    stubMode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      transact(n % 2, $urandom, $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    stubMode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      abortInG2(i);
      transact(i, 32'h1, 32'h2, 32'h0, 32'h0, 0, 0, "postreset");
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
